bp_be_fp_wb_sched: RTL and testbench

BP_BE_FP_WB_SCHED -- requirements
Module: bp_be_fp_wb_sched

---
 rtl/bp_be_pkg.sv | 16 +
 rtl/bp_be_fp_wb_slot_popcount.sv | 18 +
 rtl/bp_be_fp_wb_sched.sv | 100 ++++++++++
 tb/tb_bp_be_fp_wb_sched.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_be_pkg.sv
// Shared FP back-end types: writeback reservation slot and latency class.
package bp_be_pkg;

  localparam int fp_reg_width_gp = 5;

  typedef enum logic {
    e_fp_lat_short = 1'b0,
    e_fp_lat_long  = 1'b1
  } bp_be_fp_lat_class_e;

  typedef struct packed {
    logic                       v;
    logic [fp_reg_width_gp-1:0] rd;
  } bp_be_fp_wb_slot_s;

endpackage

// File: rtl/bp_be_fp_wb_slot_popcount.sv
// Counts the set bits of a slot-valid vector.
module bp_be_fp_wb_slot_popcount #(
  parameter int els_p         = 4,
  parameter int count_width_p = $clog2(els_p + 1)
) (
  input  logic [els_p-1:0]         v_i,
  output logic [count_width_p-1:0] count_o
);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    count_o = '0;
    for (int i = 0; i < els_p; i++) begin
      count_o = count_o + count_width_p'(v_i[i]);
    end
  end

endmodule

// File: rtl/bp_be_fp_wb_sched.sv
// FP writeback scheduler: reservation shift register that books a writeback slot at issue.
module bp_be_fp_wb_sched
  import bp_be_pkg::*;
#(
  parameter int fma_latency_p = 4,
  parameter int aux_latency_p = 2
) (
  input  logic                                 clk_i,
  input  logic                                 reset_n_i,
  input  logic                                 issue_v_i,
  input  logic                                 issue_long_i,
  input  logic [4:0]                           issue_rd_i,
  output logic                                 issue_ready_o,
  input  logic                                 kill_i,
  output logic                                 wb_v_o,
  output logic [4:0]                           wb_rd_o,
  input  logic [4:0]                           wb_fflags_i,
  input  logic                                 fflags_clear_i,
  output logic [4:0]                           fflags_o,
  input  logic [4:0]                           query_rd_i,
  output logic                                 query_busy_o,
  output logic [$clog2(fma_latency_p+1)-1:0]   inflight_o
);

  localparam int inflight_width_lp = $clog2(fma_latency_p + 1);

  bp_be_fp_wb_slot_s r_q [1:fma_latency_p];
  bp_be_fp_wb_slot_s r_n [1:fma_latency_p];

  bp_be_fp_lat_class_e          lat_class;
  logic                         slot_free;
  logic                         accept;
  logic [fma_latency_p-1:0]     v_n;
  logic [inflight_width_lp-1:0] inflight_n;
  logic [4:0]                   wb_flags;
  logic [4:0]                   fflags_n;

  assign lat_class = issue_long_i ? e_fp_lat_long : e_fp_lat_short;

  // A short op collides only if the op one slot above its landing slot shifts into it.
  always_comb begin
    slot_free = 1'b1;
    if (lat_class == e_fp_lat_short) slot_free = ~r_q[aux_latency_p+1].v;
    issue_ready_o = reset_n_i & ~kill_i & slot_free;
  end

  assign accept = issue_v_i & issue_ready_o;

  always_comb begin
    for (int k = 1; k < fma_latency_p; k++) r_n[k] = r_q[k+1];
    r_n[fma_latency_p] = '0;
    if (kill_i) begin
      for (int k = 1; k <= fma_latency_p; k++) r_n[k].v = 1'b0;
    end else if (accept) begin
      if (lat_class == e_fp_lat_long) r_n[fma_latency_p] = '{v: 1'b1, rd: issue_rd_i};
      else                            r_n[aux_latency_p] = '{v: 1'b1, rd: issue_rd_i};
    end
  end

  always_comb begin
    v_n = '0;
    for (int k = 1; k <= fma_latency_p; k++) v_n[k-1] = r_n[k].v;
  end

  bp_be_fp_wb_slot_popcount #(
    .els_p        (fma_latency_p),
    .count_width_p(inflight_width_lp)
  ) popcount (
    .v_i    (v_n),
    .count_o(inflight_n)
  );

  assign wb_flags = wb_v_o ? wb_fflags_i : 5'b0;
  assign fflags_n = fflags_clear_i ? wb_flags : (fflags_o | wb_flags);

  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!reset_n_i) begin
      // NOTE: only the valid bits need reset; rd of an invalid slot is never observed.
      for (int k = 1; k <= fma_latency_p; k++) r_q[k].v <= 1'b0;
      fflags_o   <= '0;
      inflight_o <= '0;
    end else begin
      r_q        <= r_n;
      fflags_o   <= fflags_n;
      inflight_o <= inflight_n;
    end
  end

  assign wb_v_o  = r_q[1].v;
  assign wb_rd_o = r_q[1].rd;

  always_comb begin
    query_busy_o = 1'b0;
    for (int k = 1; k <= fma_latency_p; k++) begin
      if (r_q[k].v && (r_q[k].rd == query_rd_i)) query_busy_o = 1'b1;
    end
  end

endmodule

// File: tb/tb_bp_be_fp_wb_sched.sv
// Directed bench for the FP writeback scheduler (fma latency 4, aux latency 2).
module tb_bp_be_fp_wb_sched;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       issue_v;
  logic       issue_long;
  logic [4:0] issue_rd;
  logic       issue_ready;
  logic       kill;
  logic       wb_v;
  logic [4:0] wb_rd;
  logic [4:0] wb_fflags;
  logic       fflags_clear;
  logic [4:0] fflags;
  logic [4:0] query_rd;
  logic       query_busy;
  logic [2:0] inflight;

  int vectors     = 0;
  int miscompares = 0;

  bp_be_fp_wb_sched #(
    .fma_latency_p(4),
    .aux_latency_p(2)
  ) dut (
    .clk_i         (clk),
    .reset_n_i     (reset_n),
    .issue_v_i     (issue_v),
    .issue_long_i  (issue_long),
    .issue_rd_i    (issue_rd),
    .issue_ready_o (issue_ready),
    .kill_i        (kill),
    .wb_v_o        (wb_v),
    .wb_rd_o       (wb_rd),
    .wb_fflags_i   (wb_fflags),
    .fflags_clear_i(fflags_clear),
    .fflags_o      (fflags),
    .query_rd_i    (query_rd),
    .query_busy_o  (query_busy),
    .inflight_o    (inflight)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "bench timeout");
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // One cycle = one rising edge; inputs are driven and outputs sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue_v      = 1'b0;
    issue_long   = 1'b0;
    issue_rd     = 5'd0;
    kill         = 1'b0;
    wb_fflags    = 5'd0;
    fflags_clear = 1'b0;
  endtask

  task automatic issue(input logic is_long, input logic [4:0] rd);
    issue_v    = 1'b1;
    issue_long = is_long;
    issue_rd   = rd;
  endtask

  task automatic drain();
    idle();
    for (int i = 0; i < 6; i++) tick();
  endtask

  initial begin
    reset_n  = 1'b0;
    query_rd = 5'd30;
    idle();
    issue(1'b1, 5'd30);
    #1;
    check("ready_in_reset", issue_ready, 1'b0);
    tick();
    tick();
    reset_n = 1'b1;
    idle();
    #1;
    check("rst_wb_v", wb_v, 1'b0);
    check("rst_inflight", inflight, 3'd0);
    check("rst_fflags", fflags, 5'd0);
    check("rst_query_busy", query_busy, 1'b0);
    check("rst_ready", issue_ready, 1'b1);

    // Single long op: writeback exactly 4 cycles after issue.
    issue(1'b1, 5'd5);
    #1;
    check("t1_ready", issue_ready, 1'b1);
    tick();
    idle();
    for (int c = 1; c <= 5; c++) begin
      check($sformatf("t1_wb_v_c%0d", c), wb_v, (c == 4) ? 1'b1 : 1'b0);
      check($sformatf("t1_inflight_c%0d", c), inflight, (c <= 4) ? 3'd1 : 3'd0);
      if (c == 4) check("t1_wb_rd", wb_rd, 5'd5);
      tick();
    end
    drain();

    // Short op blocked by an older long op that would land in the same slot.
    issue(1'b1, 5'd3);
    tick();
    idle();
    tick();
    issue(1'b0, 5'd7);
    #1;
    check("t2_short_blocked", issue_ready, 1'b0);
    issue_long = 1'b1;
    #1;
    check("t2_long_ok_same_cycle", issue_ready, 1'b1);
    issue_long = 1'b0;
    #1;
    tick();
    issue(1'b0, 5'd7);
    #1;
    check("t2_short_accepted", issue_ready, 1'b1);
    tick();
    idle();
    check("t2_c4_wb_v", wb_v, 1'b1);
    check("t2_c4_wb_rd", wb_rd, 5'd3);
    check("t2_c4_inflight", inflight, 3'd2);
    tick();
    check("t2_c5_wb_v", wb_v, 1'b1);
    check("t2_c5_wb_rd", wb_rd, 5'd7);
    tick();
    check("t2_c6_wb_v", wb_v, 1'b0);
    drain();

    // Kill flushes in-flight ops and drops a same-cycle issue.
    issue(1'b1, 5'd9);
    tick();
    idle();
    tick();
    issue(1'b0, 5'd1);
    kill = 1'b1;
    #1;
    check("t3_ready_kill", issue_ready, 1'b0);
    tick();
    idle();
    check("t3_c3_inflight", inflight, 3'd0);
    tick();
    check("t3_c4_wb_v", wb_v, 1'b0);
    tick();
    check("t3_c5_wb_v", wb_v, 1'b0);
    drain();

    // Writeback in the kill cycle still happens.
    issue(1'b1, 5'd4);
    tick();
    idle();
    tick();
    tick();
    tick();
    kill = 1'b1;
    #1;
    check("t3b_kill_cycle_wb_v", wb_v, 1'b1);
    check("t3b_kill_cycle_wb_rd", wb_rd, 5'd4);
    drain();

    // Accrued flags: ignored without wb, sticky OR, clear concurrent with wb.
    issue(1'b1, 5'd1);
    wb_fflags = 5'b11111;
    tick();
    issue(1'b1, 5'd2);
    tick();
    issue(1'b1, 5'd3);
    tick();
    idle();
    wb_fflags = 5'b11111;
    tick();
    idle();
    check("t4_c4_wb_v", wb_v, 1'b1);
    check("t4_c4_wb_rd", wb_rd, 5'd1);
    check("t4_flags_ignored", fflags, 5'b00000);
    wb_fflags = 5'b00001;
    tick();
    check("t4_flags_first", fflags, 5'b00001);
    wb_fflags = 5'b10000;
    tick();
    check("t4_flags_accrued", fflags, 5'b10001);
    check("t4_c6_wb_rd", wb_rd, 5'd3);
    fflags_clear = 1'b1;
    wb_fflags    = 5'b00100;
    tick();
    check("t4_clear_with_wb", fflags, 5'b00100);
    fflags_clear = 1'b1;
    wb_fflags    = 5'b11111;
    tick();
    idle();
    check("t4_clear_no_wb", fflags, 5'b00000);
    drain();

    // RAW query against an in-flight destination; its wb also leaves flags for the reset test.
    query_rd = 5'd12;
    issue(1'b1, 5'd12);
    #1;
    check("t5_c0_busy", query_busy, 1'b0);
    tick();
    idle();
    for (int c = 1; c <= 5; c++) begin
      check($sformatf("t5_busy_c%0d", c), query_busy, (c <= 4) ? 1'b1 : 1'b0);
      if (c == 2) begin
        query_rd = 5'd13;
        #1;
        check("t5_other_rd", query_busy, 1'b0);
        query_rd = 5'd12;
      end
      if (c == 4) wb_fflags = 5'b01000;
      tick();
      wb_fflags = 5'd0;
    end
    check("t5_flags", fflags, 5'b01000);
    drain();

    // Synchronous reset with two ops in flight.
    issue(1'b1, 5'd6);
    tick();
    issue(1'b0, 5'd8);
    #1;
    check("t6_short_ready", issue_ready, 1'b1);
    tick();
    reset_n = 1'b0;
    issue(1'b1, 5'd11);
    #1;
    check("t6_ready_in_reset", issue_ready, 1'b0);
    check("t6_inflight_before", inflight, 3'd2);
    tick();
    reset_n = 1'b1;
    idle();
    #1;
    check("t6_fflags", fflags, 5'd0);
    check("t6_inflight", inflight, 3'd0);
    for (int c = 3; c <= 7; c++) begin
      check($sformatf("t6_wb_v_c%0d", c), wb_v, 1'b0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
